// File: rtl/bcd_down_counter2.sv
// Two-digit BCD down counter with load, one-shot or auto-reload mode,
// terminal-count borrow output for cascading, and a sticky invalid-load flag.
module bcd_down_counter2 (
    input  logic       clk,
    input  logic       r,
    input  logic       EC,
    input  logic       LD,
    input  logic [7:0] D,
    input  logic       RL,
    output logic [7:0] Q,
    output logic       TC,
    output logic       DONE,
    output logic       ERR
);

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned CNT_W   = 2 * DIGIT_W;
    localparam int unsigned BCD_MAX = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   q_q, q_d;
    logic [CNT_W-1:0]   rv_q, rv_d;
    logic               err_q, err_d;
    logic               done_q, done_d;

    logic               load_valid;
    logic               q_zero;

    // A load is accepted only when both nibbles are legal decimal digits
    assign load_valid = (D[7:4] <= DIGIT_W'(BCD_MAX)) && (D[3:0] <= DIGIT_W'(BCD_MAX));
    assign q_zero     = (q_q == CNT_W'(0));

    // Next-state and datapath: load has priority over counting; EC only acts in RUN
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        rv_d    = rv_q;
        err_d   = err_q;
        done_d  = done_q;

        if (LD) begin
            if (load_valid) begin
                q_d     = D;
                rv_d    = D;
                err_d   = 1'b0;
                state_d = (D == CNT_W'(0)) ? ST_DONE : ST_RUN;
            end else begin
                err_d   = 1'b1;
            end
        end else if ((state_q == ST_RUN) && EC) begin
            if (!q_zero) begin
                if (q_q[3:0] != DIGIT_W'(0)) begin
                    q_d = {q_q[7:4], DIGIT_W'(q_q[3:0] - DIGIT_W'(1))};
                end else begin
                    q_d = {DIGIT_W'(q_q[7:4] - DIGIT_W'(1)), DIGIT_W'(BCD_MAX)};
                end
            end else if (RL) begin
                q_d = rv_q;
            end else begin
                state_d = ST_DONE;
            end
        end

        done_d = (state_d == ST_DONE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (r) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            rv_q    <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            rv_q    <= rv_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign Q    = q_q;
    assign DONE = done_q;
    assign ERR  = err_q;
    // Borrow-out is combinational so it can enable the next stage in the same cycle
    assign TC   = (state_q == ST_RUN) && q_zero && EC;

endmodule

// File: tb/tb_bcd_down_counter2.sv
// Self-checking bench for bcd_down_counter2: directed table, scenario
// sequences and randomized traffic against a decimal reference model.
module tb_bcd_down_counter2;

    logic       clk = 1'b0;
    logic       r, EC, LD, RL;
    logic [7:0] D;
    logic [7:0] Q;
    logic       TC, DONE, ERR;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: count held as a plain decimal integer
    int m_val, m_rv, m_st;      // m_st: 0 idle, 1 run, 2 done
    bit m_err;
    bit m_known = 1'b0;

    bcd_down_counter2 dut (
        .clk (clk),
        .r   (r),
        .EC  (EC),
        .LD  (LD),
        .D   (D),
        .RL  (RL),
        .Q   (Q),
        .TC  (TC),
        .DONE(DONE),
        .ERR (ERR)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit rr, ld, ec, rl, input logic [7:0] dd);
        int hi, lo;
        hi = int'(dd[7:4]);
        lo = int'(dd[3:0]);
        if (rr) begin
            m_val = 0; m_rv = 0; m_st = 0; m_err = 0; m_known = 1'b1;
        end else if (ld) begin
            if (hi <= 9 && lo <= 9) begin
                m_val = hi * 10 + lo;
                m_rv  = m_val;
                m_err = 0;
                m_st  = (m_val == 0) ? 2 : 1;
            end else begin
                m_err = 1;
            end
        end else if (m_st == 1 && ec) begin
            if (m_val > 0)   m_val = m_val - 1;
            else if (rl)     m_val = m_rv;
            else             m_st  = 2;
        end
    endtask

    // One clock: drive, check TC mid-cycle, clock, then check registered outputs
    task automatic cycle(input bit rr, ld, ec, rl, input logic [7:0] dd, output bit tc_seen);
        r = rr; LD = ld; EC = ec; RL = rl; D = dd;
        #4;
        tc_seen = TC;
        if (m_known)
            chk("tc", int'(TC), int'(m_st == 1 && m_val == 0 && ec && !rr ? 1 : (m_st == 1 && m_val == 0 && ec)));
        @(posedge clk);
        #1;
        model_step(rr, ld, ec, rl, dd);
        chk("q", int'(Q), int'(to_bcd(m_val)));
        chk("done", int'(DONE), (m_st == 2) ? 1 : 0);
        chk("err", int'(ERR), int'(m_err));
        chk("q_nibbles_bcd", (Q[7:4] <= 4'd9 && Q[3:0] <= 4'd9) ? 1 : 0, 1);
    endtask

    typedef struct {
        bit         r, ld, ec, rl;
        logic [7:0] d;
        logic [7:0] q;
        bit         tc, done, err;
    } vec_t;

    vec_t tbl[17];

    initial begin
        bit tc;
        int pulses, last_tc;
        int exp36[10];
        r = 1'b0; LD = 1'b0; EC = 1'b0; RL = 1'b0; D = 8'h00;
        m_val = 0; m_rv = 0; m_st = 0; m_err = 0;

        //          r  ld ec rl  d      q      tc done err
        tbl[0]  = '{1, 1, 1, 0, 8'h55, 8'h00, 0, 0, 0};
        tbl[1]  = '{0, 1, 1, 0, 8'h12, 8'h12, 0, 0, 0};
        tbl[2]  = '{0, 0, 1, 0, 8'h00, 8'h11, 0, 0, 0};
        tbl[3]  = '{0, 0, 1, 0, 8'h00, 8'h10, 0, 0, 0};
        tbl[4]  = '{0, 0, 1, 0, 8'h00, 8'h09, 0, 0, 0};
        tbl[5]  = '{0, 1, 0, 0, 8'h3A, 8'h09, 0, 0, 1};
        tbl[6]  = '{0, 0, 1, 0, 8'h00, 8'h08, 0, 0, 1};
        tbl[7]  = '{0, 1, 0, 0, 8'h05, 8'h05, 0, 0, 0};
        tbl[8]  = '{0, 0, 0, 0, 8'h00, 8'h05, 0, 0, 0};
        tbl[9]  = '{0, 1, 1, 0, 8'h00, 8'h00, 0, 1, 0};
        tbl[10] = '{0, 0, 1, 0, 8'h00, 8'h00, 0, 1, 0};
        tbl[11] = '{0, 1, 0, 0, 8'h9A, 8'h00, 0, 1, 1};
        tbl[12] = '{0, 1, 0, 0, 8'hA0, 8'h00, 0, 1, 1};
        tbl[13] = '{1, 0, 1, 0, 8'h00, 8'h00, 0, 0, 0};
        tbl[14] = '{0, 0, 1, 0, 8'h00, 8'h00, 0, 0, 0};
        tbl[15] = '{0, 1, 0, 1, 8'h99, 8'h99, 0, 0, 0};
        tbl[16] = '{0, 0, 1, 1, 8'h00, 8'h98, 0, 0, 0};

        @(posedge clk);
        #1;

        // Directed table
        for (int i = 0; i < 17; i++) begin
            cycle(tbl[i].r, tbl[i].ld, tbl[i].ec, tbl[i].rl, tbl[i].d, tc);
            if (i > 0) chk($sformatf("tbl%0d_tc", i), int'(tc), int'(tbl[i].tc));
            chk($sformatf("tbl%0d_q", i), int'(Q), int'(tbl[i].q));
            chk($sformatf("tbl%0d_done", i), int'(DONE), int'(tbl[i].done));
            chk($sformatf("tbl%0d_err", i), int'(ERR), int'(tbl[i].err));
        end

        // One-shot from 12: 12 decrements, one TC at 00, then DONE and hold
        cycle(1, 0, 0, 0, 8'h00, tc);
        cycle(0, 1, 1, 0, 8'h12, tc);
        chk("s35_load_q", int'(Q), 'h12);
        pulses = 0;
        for (int k = 1; k <= 16; k++) begin
            cycle(0, 0, 1, 0, 8'h00, tc);
            if (tc) pulses++;
            if (k <= 12) chk($sformatf("s35_q_step%0d", k), int'(Q), int'(to_bcd(12 - k)));
            if (k == 13) begin
                chk("s35_tc_at_00", int'(tc), 1);
                chk("s35_done", int'(DONE), 1);
            end
            if (k > 13) chk("s35_hold00", int'(Q), 0);
        end
        chk("s35_tc_pulses", pulses, 1);

        // Auto-reload from 03: TC every 4 enabled cycles
        exp36 = '{2, 1, 0, 3, 2, 1, 0, 3, 2, 1};
        cycle(0, 1, 1, 1, 8'h03, tc);
        chk("s36_load_q", int'(Q), 'h03);
        pulses = 0; last_tc = -1;
        for (int k = 0; k < 10; k++) begin
            cycle(0, 0, 1, 1, 8'h00, tc);
            chk($sformatf("s36_q%0d", k), int'(Q), int'(to_bcd(exp36[k])));
            if (tc) begin
                if (last_tc >= 0) chk("s36_tc_spacing", k - last_tc, 4);
                last_tc = k;
                pulses++;
            end
        end
        chk("s36_tc_pulses", pulses, 2);

        // Load wins over count on the same edge, then hold with EC=0
        cycle(0, 1, 0, 0, 8'h41, tc);
        cycle(0, 0, 1, 0, 8'h00, tc);
        chk("s38_at40", int'(Q), 'h40);
        cycle(0, 1, 1, 0, 8'h77, tc);
        chk("s38_load_wins", int'(Q), 'h77);
        for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0, 8'h00, tc);
        chk("s38_hold", int'(Q), 'h77);

        // Reset beats a simultaneous load in RUN; EC alone then does nothing
        cycle(0, 1, 0, 0, 8'h26, tc);
        cycle(0, 0, 1, 0, 8'h00, tc);
        chk("s39_at25", int'(Q), 'h25);
        cycle(1, 1, 1, 0, 8'h44, tc);
        chk("s39_q", int'(Q), 0);
        chk("s39_done", int'(DONE), 0);
        cycle(0, 0, 1, 0, 8'h00, tc);
        chk("s39_idle_tc", int'(tc), 0);
        chk("s39_idle_q", int'(Q), 0);

        // Mode switch mid-count: reload only decided at terminal count
        cycle(0, 1, 0, 0, 8'h02, tc);
        cycle(0, 0, 1, 0, 8'h00, tc);
        cycle(0, 0, 1, 1, 8'h00, tc);
        cycle(0, 0, 1, 1, 8'h00, tc);
        chk("rl_switch_tc", int'(tc), 1);
        chk("rl_switch_reload", int'(Q), 'h02);

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            bit rr, ld, ec, rl;
            logic [7:0] dd;
            rr = ($urandom_range(0, 99) < 2);
            ld = ($urandom_range(0, 99) < 8);
            ec = ($urandom_range(0, 99) < 75);
            rl = ($urandom_range(0, 99) < 60);
            if ($urandom_range(0, 3) == 0) dd = 8'($urandom);
            else dd = to_bcd(int'($urandom_range(0, 15) == 0 ? 0 : $urandom_range(0, 30)));
            cycle(rr, ld, ec, rl, dd, tc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bcd_down_counter2.md
BCD_DOWN_COUNTER2 -- requirements
Module: bcd_down_counter2

Interface
REQ-001 The block SHALL have no parameters; width is fixed at two BCD digits (00-99).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 r  input  1  reset, synchronous, active-high.
REQ-004 EC  input  1  count enable; one decrement per enabled cycle in RUN.
REQ-005 LD  input  1  load strobe; samples D.
REQ-006 D  input  8  load value; D[7:4] tens digit, D[3:0] units digit.
REQ-007 RL  input  1  auto-reload mode select (1 = reload on terminal count, 0 = one-shot).
REQ-008 Q  output  8  current count, BCD; Q[7:4] tens, Q[3:0] units.
REQ-009 TC  output  1  terminal count / borrow-out for cascading, combinational.
REQ-010 DONE  output  1  one-shot expired flag, registered.
REQ-011 ERR  output  1  invalid-load flag, registered, sticky.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-013 The block SHALL hold an 8-bit reload register RV, written only by a valid load.
REQ-014 A load SHALL be valid when both D nibbles are <= 9, and invalid otherwise.
REQ-015 Priority SHALL be r > LD > EC in every state.
REQ-016 Valid LD with D != 8'h00: Q <= D, RV <= D, ERR <= 0, state <= RUN, on the same edge.
REQ-017 Valid LD with D == 8'h00: Q <= 8'h00, RV <= 8'h00, ERR <= 0, state <= DONE.
REQ-018 Invalid LD: Q, RV and state unchanged; ERR <= 1.
REQ-019 ERR SHALL stay 1 until the next valid load or reset.
REQ-020 RUN, EC=1, Q != 00: decrement in BCD.
  - units != 0: units - 1.
  - units == 0: units <= 9 and tens - 1.
REQ-021 RUN, EC=1, Q == 00, RL=1: Q <= RV; stay in RUN.
REQ-022 RUN, EC=1, Q == 00, RL=0: Q stays 8'h00; state <= DONE.
REQ-023 RUN, EC=0: Q and state hold.
REQ-024 IDLE and DONE: EC SHALL be ignored; Q holds; only LD or r leaves these states.
REQ-025 TC SHALL equal (state == RUN) & (Q == 8'h00) & EC, with no register delay.
  - TC pulses for exactly one enabled cycle per terminal count.
  - TC drives EC of a following stage.
REQ-026 With RL=1 and load value N (N != 0), TC SHALL pulse once every N+1 enabled cycles.
REQ-027 DONE SHALL be 1 exactly while state == DONE.
REQ-028 Q SHALL never hold a nibble greater than 9.
REQ-029 Changing RL in mid-count SHALL take effect at the next terminal count only.

Reset
REQ-030 When r=1 at a clock edge, the block SHALL enter IDLE with Q=8'h00, RV=8'h00, DONE=0, ERR=0.
REQ-031 TC SHALL be 0 while in IDLE.
REQ-032 Reset SHALL override a simultaneous LD or EC.
REQ-033 Reset during RUN SHALL abort the count with no TC pulse.
REQ-034 The first clock edge with r=0 SHALL honour LD.

Verification
REQ-035 Scenario: reset, then LD with D=8'h12, RL=0, EC=1 held.
  - Required: Q = 12, 11, 10, 09, ..., 00.
  - Required: TC=1 for one cycle at Q=00.
  - Required: DONE=1 on the next edge; Q holds 00 afterwards.
REQ-036 Scenario: LD with D=8'h03, RL=1, EC=1 for 10 cycles.
  - Required: Q = 03, 02, 01, 00, 03, 02, ...
  - Required: TC pulses are 4 cycles apart.
REQ-037 Scenario: LD with D=8'h3A.
  - Required: ERR=1; Q and state unchanged.
  - Then: LD with D=8'h05 gives ERR=0 and Q=05.
REQ-038 Scenario: in RUN at Q=8'h40, EC=1 and LD=1 with D=8'h77 on the same edge.
  - Required: Q=77 (load wins).
  - Then: EC=0 for 3 cycles gives Q=77 held.
REQ-039 Scenario: in RUN at Q=8'h25, assert r together with LD.
  - Required: Q=00, IDLE, TC=0, DONE=0.
  - Then: EC=1 alone leaves Q at 00.
REQ-040 Scenario: LD with D=8'h00.
  - Required: DONE=1 on the next edge and TC never asserts.
  - Also: all Q nibbles stay <= 9 in every scenario.
